tx_mac_stream: RTL and testbench

- Transmit-side data mover for the e1000 TX path; the counterpart of the RX path's MAC receive port.
- Accepts segment commands from the TX engine and reads packet bytes from the local data RAM over an AXI3 read channel.
- Streams the bytes to the MAC TX AXI-Stream port, with tkeep/tlast framing.
- Returns one status word per command.

---
 rtl/e1000_tx_pkg.sv | 34 +++
 rtl/tx_mac_stream.sv | 172 +++++++++++++++++
 tb/tb_tx_mac_stream.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/e1000_tx_pkg.sv
// rtl/e1000_tx_pkg.sv - shared constants, state encoding and helpers for the e1000 TX data mover
package e1000_tx_pkg;

    // Command beat 0 fields
    localparam int CMD_LEN_LSB = 0;
    localparam int CMD_LEN_W   = 16;
    localparam int CMD_EOP_BIT = 16;

    // Status word fields
    localparam int STS_ERR_BIT   = 31;
    localparam int STS_BYTES_LSB = 0;
    localparam int STS_BYTES_W   = 16;

    // AXI constants
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD1 = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_RPT  = 3'd4
    } tx_state_t;

    // Dword beats needed to carry len bytes: ceil(len/4)
    function automatic logic [14:0] beats_of(input logic [15:0] len);
        logic [16:0] sum;
        sum = {1'b0, len} + 17'd3;
        return sum[16:2];
    endfunction

endpackage

// File: rtl/tx_mac_stream.sv
// rtl/tx_mac_stream.sv - TX data mover: command in, AXI3 RAM reads, MAC AXI-Stream out, status out
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   cmd_s_*              2-beat segment command stream (beat0 LEN/EOP, beat1 start address)
//   rpt_m_*              one status word per command: [31] ERR, [15:0] bytes forwarded
//   ram_m_ar*            AXI3 read address channel to the local data RAM
//   ram_m_r*             AXI3 read data channel from the local data RAM
//   mac_m_*              frame stream to the MAC, byte 0 in [7:0]
module tx_mac_stream
    import e1000_tx_pkg::*;
#(
    parameter int DATA_RAM_DWORDS = 16384,
    parameter int MAX_BURST       = 16,
    localparam int DATA_RAM_AW    = $clog2(DATA_RAM_DWORDS) + 2
) (
    input  logic                   aclk,
    input  logic                   aresetn,

    input  logic [31:0]            cmd_s_tdata,
    input  logic                   cmd_s_tvalid,
    input  logic                   cmd_s_tlast,
    output logic                   cmd_s_tready,

    output logic [31:0]            rpt_m_tdata,
    output logic                   rpt_m_tvalid,
    output logic                   rpt_m_tlast,
    input  logic                   rpt_m_tready,

    output logic [3:0]             ram_m_arid,
    output logic [DATA_RAM_AW-1:0] ram_m_araddr,
    output logic [3:0]             ram_m_arlen,
    output logic [2:0]             ram_m_arsize,
    output logic [1:0]             ram_m_arburst,
    output logic                   ram_m_arvalid,
    input  logic                   ram_m_arready,
    input  logic [3:0]             ram_m_rid,
    input  logic [31:0]            ram_m_rdata,
    input  logic [1:0]             ram_m_rresp,
    input  logic                   ram_m_rlast,
    input  logic                   ram_m_rvalid,
    output logic                   ram_m_rready,

    output logic [31:0]            mac_m_tdata,
    output logic [3:0]             mac_m_tkeep,
    output logic                   mac_m_tvalid,
    output logic                   mac_m_tlast,
    input  logic                   mac_m_tready
);

    localparam logic [14:0] BURST_BEATS = 15'(MAX_BURST);

    tx_state_t              state, state_nxt;
    logic [15:0]            len;
    logic                   eop;
    logic [14:0]            beats;
    logic [DATA_RAM_AW-1:0] addr;
    logic                   err;
    logic [15:0]            bytes;
    logic                   run;

    logic                   cmd_xfer;
    logic                   beat_xfer;
    logic                   final_beat;
    logic                   cmd_bad;

    logic                   unused_ok;
    assign unused_ok = ^{ram_m_rid, cmd_s_tdata};

    assign cmd_xfer   = cmd_s_tvalid && cmd_s_tready;
    assign beat_xfer  = (state == ST_DATA) && ram_m_rvalid && mac_m_tready;
    assign final_beat = (beats == 15'd1);
    // Zero length, or a non-final segment that is not a whole number of dwords
    assign cmd_bad    = (len == 16'd0) || (!eop && (len[1:0] != 2'b00));

    // run holds ready low during reset and the first cycle after it
    assign cmd_s_tready  = run && ((state == ST_IDLE) || (state == ST_CMD1));

    assign rpt_m_tvalid  = (state == ST_RPT);
    assign rpt_m_tlast   = rpt_m_tvalid;
    assign rpt_m_tdata   = {err, 15'd0, bytes};

    assign ram_m_arid    = 4'd0;
    assign ram_m_arsize  = SIZE_4B;
    assign ram_m_arburst = BURST_INCR;
    assign ram_m_araddr  = addr;
    assign ram_m_arvalid = (state == ST_ADDR);
    assign ram_m_arlen   = (beats >= BURST_BEATS) ? 4'(MAX_BURST - 1) : 4'(beats - 15'd1);

    // Zero-latency data pass-through while in DATA
    assign ram_m_rready  = (state == ST_DATA) && mac_m_tready;
    assign mac_m_tvalid  = (state == ST_DATA) && ram_m_rvalid;
    assign mac_m_tdata   = ram_m_rdata;
    assign mac_m_tlast   = (state == ST_DATA) && eop && final_beat;

    always_comb begin
        mac_m_tkeep = 4'b1111;
        if (mac_m_tlast) begin
            case (len[1:0])
                2'd1:    mac_m_tkeep = 4'b0001;
                2'd2:    mac_m_tkeep = 4'b0011;
                2'd3:    mac_m_tkeep = 4'b0111;
                default: mac_m_tkeep = 4'b1111;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cmd_xfer) state_nxt = cmd_s_tlast ? ST_RPT : ST_CMD1;
            ST_CMD1: if (cmd_xfer) state_nxt = cmd_bad ? ST_RPT : ST_ADDR;
            ST_ADDR: if (ram_m_arready) state_nxt = ST_DATA;
            ST_DATA: begin
                if (beat_xfer) begin
                    if (final_beat)       state_nxt = ST_RPT;
                    else if (ram_m_rlast) state_nxt = ST_ADDR;
                end
            end
            ST_RPT:  if (rpt_m_tready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
            len   <= '0;
            eop   <= 1'b0;
            beats <= '0;
            addr  <= '0;
            err   <= 1'b0;
            bytes <= '0;
            run   <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (cmd_xfer) begin
                        len <= cmd_s_tdata[CMD_LEN_LSB +: CMD_LEN_W];
                        eop <= cmd_s_tdata[CMD_EOP_BIT];
                        if (cmd_s_tlast) err <= 1'b1;
                    end
                end
                ST_CMD1: begin
                    if (cmd_xfer) begin
                        addr  <= {cmd_s_tdata[DATA_RAM_AW-1:2], 2'b00};
                        beats <= beats_of(len);
                        if (cmd_bad) err   <= 1'b1;
                        else         bytes <= len;
                    end
                end
                ST_DATA: begin
                    if (beat_xfer) begin
                        beats <= beats - 15'd1;
                        addr  <= addr + DATA_RAM_AW'(4);
                        if (ram_m_rresp != RESP_OKAY) err <= 1'b1;
                    end
                end
                ST_RPT: begin
                    if (rpt_m_tready) begin
                        err   <= 1'b0;
                        bytes <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_mac_stream.sv
// tb/tb_tx_mac_stream.sv - scoreboard bench for tx_mac_stream
module tb_tx_mac_stream;

    localparam int AW = 16;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] cmd_s_tdata;
    logic        cmd_s_tvalid, cmd_s_tlast, cmd_s_tready;
    logic [31:0] rpt_m_tdata;
    logic        rpt_m_tvalid, rpt_m_tlast, rpt_m_tready;
    logic [3:0]  ram_m_arid, ram_m_arlen, ram_m_rid;
    logic [AW-1:0] ram_m_araddr;
    logic [2:0]  ram_m_arsize;
    logic [1:0]  ram_m_arburst, ram_m_rresp;
    logic        ram_m_arvalid, ram_m_arready, ram_m_rlast, ram_m_rvalid, ram_m_rready;
    logic [31:0] ram_m_rdata, mac_m_tdata;
    logic [3:0]  mac_m_tkeep;
    logic        mac_m_tvalid, mac_m_tlast, mac_m_tready;

    tx_mac_stream dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_s_tdata(cmd_s_tdata), .cmd_s_tvalid(cmd_s_tvalid), .cmd_s_tlast(cmd_s_tlast), .cmd_s_tready(cmd_s_tready),
        .rpt_m_tdata(rpt_m_tdata), .rpt_m_tvalid(rpt_m_tvalid), .rpt_m_tlast(rpt_m_tlast), .rpt_m_tready(rpt_m_tready),
        .ram_m_arid(ram_m_arid), .ram_m_araddr(ram_m_araddr), .ram_m_arlen(ram_m_arlen), .ram_m_arsize(ram_m_arsize),
        .ram_m_arburst(ram_m_arburst), .ram_m_arvalid(ram_m_arvalid), .ram_m_arready(ram_m_arready),
        .ram_m_rid(ram_m_rid), .ram_m_rdata(ram_m_rdata), .ram_m_rresp(ram_m_rresp), .ram_m_rlast(ram_m_rlast),
        .ram_m_rvalid(ram_m_rvalid), .ram_m_rready(ram_m_rready),
        .mac_m_tdata(mac_m_tdata), .mac_m_tkeep(mac_m_tkeep), .mac_m_tvalid(mac_m_tvalid), .mac_m_tlast(mac_m_tlast),
        .mac_m_tready(mac_m_tready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t       exp_beats[$];
    logic [19:0] exp_ar[$];
    logic [31:0] exp_rpt[$];

    int n_checks = 0;
    int n_errors = 0;
    int beat_base = 0;
    int inj_at = -1;
    int served = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ram_word(input logic [AW-1:0] a);
        return {~a, a} ^ 32'h5A3C_0F69;
    endfunction

    function automatic logic [3:0] keep_of(input logic [1:0] r);
        case (r)
            2'd1:    return 4'b0001;
            2'd2:    return 4'b0011;
            2'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic drive_beat(input logic [31:0] d, input logic last);
        int n;
        cmd_s_tdata  = d;
        cmd_s_tlast  = last;
        cmd_s_tvalid = 1'b1;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!cmd_s_tready && n < 5000);
        if (!cmd_s_tready) chk("cmd_accept_timeout", 0, 1);
        @(posedge aclk); #1;
        cmd_s_tvalid = 1'b0;
        cmd_s_tlast  = 1'b0;
    endtask

    // Pushes all expectations for one command, then drives it
    task automatic send_cmd(input int len, input bit eop, input logic [AW-1:0] addr,
                            input bit malformed, input int rresp_beat);
        int nb, rem, n;
        logic [AW-1:0] a;
        beat_t b;
        bit bad;
        bad = malformed || (len == 0) || (!eop && (len % 4 != 0));
        if (bad) begin
            exp_rpt.push_back(32'h8000_0000);
        end else begin
            nb = (len + 3) / 4;
            if (rresp_beat >= 0) inj_at = beat_base + rresp_beat;
            rem = nb;
            a = addr;
            while (rem > 0) begin
                n = (rem > 16) ? 16 : rem;
                exp_ar.push_back({a, 4'(n - 1)});
                a = a + AW'(4 * n);
                rem -= n;
            end
            for (int i = 0; i < nb; i++) begin
                b.d = ram_word(addr + AW'(4 * i));
                b.l = eop && (i == nb - 1);
                b.k = b.l ? keep_of(2'(len % 4)) : 4'b1111;
                exp_beats.push_back(b);
            end
            beat_base += nb;
            exp_rpt.push_back({(rresp_beat >= 0), 15'd0, 16'(len)});
        end
        drive_beat({15'd0, eop, 16'(len)}, malformed);
        if (!malformed) drive_beat({16'd0, addr}, 1'b1);
    endtask

    // RAM read slave: one burst at a time, random arready and rvalid gaps
    initial begin
        logic [AW-1:0] a;
        logic [3:0] l;
        logic [19:0] e;
        int n;
        ram_m_arready = 1'b0;
        ram_m_rvalid  = 1'b0;
        ram_m_rdata   = '0;
        ram_m_rresp   = 2'b00;
        ram_m_rlast   = 1'b0;
        ram_m_rid     = 4'd0;
        forever begin
            @(posedge aclk); #1;
            ram_m_arready = ($urandom_range(0, 1) == 1);
            @(negedge aclk);
            if (aresetn && ram_m_arvalid && ram_m_arready) begin
                a = ram_m_araddr;
                l = ram_m_arlen;
                if (exp_ar.size() == 0) begin
                    chk("ar_unexpected", {a, l}, 0);
                end else begin
                    e = exp_ar.pop_front();
                    chk("ar_addr", a, e[19:4]);
                    chk("ar_len", l, e[3:0]);
                end
                @(posedge aclk); #1;
                ram_m_arready = 1'b0;
                for (int b = 0; b <= int'(l); b++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        ram_m_rvalid = 1'b0;
                        @(posedge aclk); #1;
                    end
                    ram_m_rvalid = 1'b1;
                    ram_m_rdata  = ram_word(a + AW'(4 * b));
                    ram_m_rresp  = (served == inj_at) ? 2'b10 : 2'b00;
                    ram_m_rlast  = (b == int'(l));
                    n = 0;
                    do begin
                        @(negedge aclk);
                        if (ram_m_arvalid) chk("ar_while_outstanding", 1, 0);
                        n++;
                    end while (!ram_m_rready && n < 5000);
                    if (!ram_m_rready) chk("r_accept_timeout", 0, 1);
                    @(posedge aclk); #1;
                    served++;
                end
                ram_m_rvalid = 1'b0;
                ram_m_rlast  = 1'b0;
                ram_m_rresp  = 2'b00;
            end
        end
    end

    // Random sink backpressure
    initial begin
        mac_m_tready = 1'b0;
        rpt_m_tready = 1'b0;
        forever begin
            @(posedge aclk); #1;
            mac_m_tready = aresetn && ($urandom_range(0, 1) == 1);
            rpt_m_tready = aresetn && ($urandom_range(0, 1) == 1);
        end
    end

    // MAC stream monitor
    initial begin
        beat_t e;
        forever begin
            @(negedge aclk);
            if (aresetn && mac_m_tvalid && mac_m_tready) begin
                if (exp_beats.size() == 0) begin
                    chk("mac_unexpected", mac_m_tdata, 0);
                end else begin
                    e = exp_beats.pop_front();
                    chk("mac_data", mac_m_tdata, e.d);
                    chk("mac_keep", mac_m_tkeep, e.k);
                    chk("mac_last", mac_m_tlast, e.l);
                end
            end
        end
    end

    // Status monitor
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge aclk);
            if (aresetn && rpt_m_tvalid && rpt_m_tready) begin
                chk("rpt_tlast", rpt_m_tlast, 1);
                if (exp_rpt.size() == 0) begin
                    chk("rpt_unexpected", rpt_m_tdata, 0);
                end else begin
                    e = exp_rpt.pop_front();
                    chk("rpt_data", rpt_m_tdata, e);
                end
            end
        end
    end

    initial begin
        int w;
        aresetn      = 1'b0;
        cmd_s_tdata  = '0;
        cmd_s_tvalid = 1'b0;
        cmd_s_tlast  = 1'b0;
        repeat (3) @(negedge aclk);
        chk("rst_cmd_tready", cmd_s_tready, 0);
        chk("rst_rpt_tvalid", rpt_m_tvalid, 0);
        chk("rst_rpt_tdata", rpt_m_tdata, 0);
        chk("rst_arvalid", ram_m_arvalid, 0);
        chk("rst_rready", ram_m_rready, 0);
        chk("rst_mac_tvalid", mac_m_tvalid, 0);
        chk("arsize", ram_m_arsize, 3'b010);
        chk("arburst", ram_m_arburst, 2'b01);
        chk("arid", ram_m_arid, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;

        send_cmd(60, 1'b1, 16'h0100, 1'b0, -1);
        send_cmd(100, 1'b1, 16'h0000, 1'b0, -1);
        send_cmd(61, 1'b1, 16'h0200, 1'b0, -1);
        send_cmd(64, 1'b0, 16'h0400, 1'b0, -1);
        send_cmd(36, 1'b1, 16'h0800, 1'b0, -1);
        send_cmd(16, 1'b1, 16'hFFF8, 1'b0, -1);
        send_cmd(40, 1'b1, 16'h1000, 1'b0, 2);
        send_cmd(0, 1'b1, 16'h0010, 1'b0, -1);
        send_cmd(6, 1'b0, 16'h0020, 1'b0, -1);
        send_cmd(8, 1'b1, 16'h0030, 1'b1, -1);
        send_cmd(8, 1'b1, 16'h0030, 1'b0, -1);

        w = 0;
        while ((exp_beats.size() != 0 || exp_ar.size() != 0 || exp_rpt.size() != 0) && w < 20000) begin
            @(negedge aclk);
            w++;
        end
        repeat (4) @(negedge aclk);
        chk("drain_beats", exp_beats.size(), 0);
        chk("drain_ar", exp_ar.size(), 0);
        chk("drain_rpt", exp_rpt.size(), 0);
        chk("idle_cmd_tready", cmd_s_tready, 1);
        chk("idle_arvalid", ram_m_arvalid, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
